// File: rtl/hart_pkg.sv
// hart_pkg -- shared types and constants for the synthetic heart-rate source.
//   WIDTH / HART_MAX : sample width and largest representable rate
//   hart_t           : one heart-rate sample
//   hart_ext_t       : one bit wider than hart_t, so step arithmetic cannot wrap
//   state_t          : generator FSM states
//   LFSR_SEED/TAPS   : noise LFSR constants (only used with HART_NOISE_EN)
//   hart_advance()   : one bounded move of hart toward a target
package hart_pkg;

  localparam int WIDTH    = 6;
  localparam int HART_MAX = 2**WIDTH - 1;

  typedef logic [WIDTH-1:0] hart_t;
  typedef logic [WIDTH:0]   hart_ext_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bit positions 7,5,4,3).
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam hart_ext_t ONE_X = hart_ext_t'(1);

  // Move cur toward tgt by min(step, distance). A zero step counts as one;
  // noise trims the step by one but never below one, so the ramp still
  // converges. Working one bit wider keeps the result inside 0..HART_MAX.
  function automatic hart_t hart_advance(hart_t cur, hart_t tgt,
                                         logic [2:0] stp, logic noise);
    hart_ext_t h, t, s, d, mv, nx;
    h = {1'b0, cur};
    t = {1'b0, tgt};
    s = (stp == 3'd0) ? ONE_X : hart_ext_t'(stp);
    if (noise && (s > ONE_X)) s = s - ONE_X;
    d  = (t > h) ? (t - h) : (h - t);
    mv = (s < d) ? s : d;
    nx = (t > h) ? (h + mv) : (h - mv);
    return nx[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/hart_prescaler.sv
// hart_prescaler -- DIV-cycle tick counter that paces ramp advances.
//   slow  in  clock, rising edge
//   reset in  asynchronous active-low reset (counter -> 0)
//   clear in  synchronous clear; holds the counter at 0 and masks tick
//   tick  out high in the cycle the counter sits at DIV-1
module hart_prescaler #(
  parameter int DIV = 2
) (
  input  logic slow,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the values from before the edge, independent of order.
  always_ff @(posedge slow or negedge reset) begin
    if (!reset)             cnt <= '0;
    else if (clear)         cnt <= '0;
    else if (cnt == LAST)   cnt <= '0;
    else                    cnt <= cnt + CW'(1);
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/hart_generator.sv
// hart_generator -- synthetic heart-rate source. Ramps a registered hart
// sample toward a commanded target in bounded steps, holds it long enough
// for a downstream 3-deep comparator to see a stable rate, then pulses
// settled.
//   slow    in   clock, rising edge
//   reset   in   asynchronous active-low reset
//   start   in   request a new ramp (accepted only in IDLE or DONE)
//   target  in   destination rate, latched on accepted start
//   step    in   max change per advance, latched on accepted start (0 -> 1)
//   hart    out  current heart-rate sample (registered)
//   busy    out  high in RAMP and HOLD (registered)
//   settled out  one-cycle pulse in DONE (registered)
// Optional feature: define HART_NOISE_EN to add an 8-bit LFSR that randomly
// shortens ramp steps by one.
module hart_generator
  import hart_pkg::*;
#(
  parameter int RESET_HART = HART_MAX,
  parameter int DIV        = 2,
  parameter int HOLD_TICKS = 4
) (
  input  logic             slow,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [2:0]       step,
  output logic [WIDTH-1:0] hart,
  output logic             busy,
  output logic             settled
);

  localparam hart_t RESET_VAL = hart_t'(RESET_HART);
  localparam int    HW        = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  state_t        state, state_d;
  hart_t         hart_q, hart_d;
  hart_t         tgt_q, tgt_d;
  logic [2:0]    stp_q, stp_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          busy_d, settled_d;
  logic          tick;
  logic          noise;

  // Prescaler only runs while ramping; every other state parks it at 0 so
  // each new ramp starts a full DIV period before its first advance.
  hart_prescaler #(.DIV(DIV)) u_prescaler (
    .slow  (slow),
    .reset (reset),
    .clear (state != RAMP),
    .tick  (tick)
  );

`ifdef HART_NOISE_EN
  logic [7:0] lfsr;

  always_ff @(posedge slow or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  assign noise = lfsr[0];
`else
  assign noise = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    hart_d  = hart_q;
    tgt_d   = tgt_q;
    stp_d   = stp_q;
    hold_d  = hold_q;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          tgt_d   = target;
          stp_d   = step;
          state_d = RAMP;
        end else begin
          state_d = IDLE;
        end
      end
      RAMP: begin
        // Equality is judged on the value at the start of the cycle, so the
        // last advance is always followed by one more RAMP cycle.
        if (hart_q == tgt_q) begin
          state_d = HOLD;
          hold_d  = '0;
        end else if (tick) begin
          hart_d = hart_advance(hart_q, tgt_q, stp_q, noise);
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) state_d = DONE;
        else                     hold_d  = hold_q + HW'(1);
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d == RAMP) || (state_d == HOLD);
    settled_d = (state_d == DONE);
  end

  always_ff @(posedge slow or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hart_q  <= RESET_VAL;
      tgt_q   <= '0;
      stp_q   <= '0;
      hold_q  <= '0;
      busy    <= 1'b0;
      settled <= 1'b0;
    end else begin
      state   <= state_d;
      hart_q  <= hart_d;
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
      hold_q  <= hold_d;
      busy    <= busy_d;
      settled <= settled_d;
    end
  end

  assign hart = hart_q;

endmodule

// File: tb/tb_hart_generator.sv
// tb_hart_generator -- self-checking bench for hart_generator.
// A job model builds the list of waypoints a ramp passes through and derives
// per-cycle hart/busy/settled from it; outputs are sampled on the falling
// edge and inputs are driven there too.
module tb_hart_generator;
  import hart_pkg::*;

  localparam int DIV  = 2;
  localparam int HOLD = 4;

  logic             slow = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] target;
  logic [2:0]       step;
  logic [WIDTH-1:0] hart;
  logic             busy;
  logic             settled;

  int n_cmp = 0;
  int n_err = 0;
  int model_hart = 63;

  hart_generator #(.RESET_HART(63), .DIV(DIV), .HOLD_TICKS(HOLD)) dut (
    .slow    (slow),
    .reset   (reset),
    .start   (start),
    .target  (target),
    .step    (step),
    .hart    (hart),
    .busy    (busy),
    .settled (settled)
  );

  always #5 slow = ~slow;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      @(negedge slow);
      check({tag, " idle hart"}, 32'(hart), 32'(model_hart));
      check({tag, " idle busy"}, 32'(busy), 0);
      check({tag, " idle settled"}, 32'(settled), 0);
    end
  endtask

  // Called at a falling edge with the DUT in IDLE or DONE. Raises start, then
  // follows the job through to its DONE cycle and returns on that falling
  // edge with start low (a caller may raise it again to chain from DONE).
  // With junk set, random start pulses (target 0) are applied while busy.
  task automatic run_job(input int tgt, input int stp, input bit junk, input string tag);
    int wp[$];
    int h, s, d, n, last, exp_h;
    h = model_hart;
    s = (stp == 0) ? 1 : stp;
    wp.push_back(h);
    while (h != tgt) begin
      d = (tgt > h) ? tgt - h : h - tgt;
      if (d > s) d = s;
      h = (tgt > h) ? h + d : h - d;
      wp.push_back(h);
    end
    n    = wp.size() - 1;
    last = n * DIV + HOLD + 1;   // cycle index of the settled pulse

    start  = 1'b1;
    target = tgt[WIDTH-1:0];
    step   = stp[2:0];
    for (int c = 0; c <= last; c++) begin
      @(negedge slow);
      exp_h = (c / DIV < n) ? wp[c / DIV] : tgt;
      check({tag, " hart"}, 32'(hart), 32'(exp_h));
      check({tag, " busy"}, 32'(busy), (c < last) ? 1 : 0);
      check({tag, " settled"}, 32'(settled), (c == last) ? 1 : 0);
      if (junk && c < last) begin
        start  = 1'($urandom_range(0, 1));
        target = '0;
        step   = 3'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
    end
    model_hart = tgt;
  endtask

  initial begin
    int t, s;
    reset  = 1'b0;
    start  = 1'b0;
    target = '0;
    step   = '0;

    #12;
    check("reset hart", 32'(hart), 63);
    check("reset busy", 32'(busy), 0);
    check("reset settled", 32'(settled), 0);
    @(negedge slow);
    reset = 1'b1;

    // Quiet after reset release.
    idle_cycles(20, "t1");

`ifndef HART_NOISE_EN
    run_job(40, 4, 1'b0, "t2 down");
    idle_cycles(2, "t2");
    run_job(45, 7, 1'b0, "t3 clamp up");
    idle_cycles(2, "t3");
    run_job(20, 3, 1'b1, "t4 ignore start");
    idle_cycles(1, "t4");
    // target equals hart, then a new job started in the DONE cycle
    run_job(20, 5, 1'b0, "t5 equal");
    run_job(45, 5, 1'b0, "t5 chained");
    idle_cycles(2, "t5");

    for (int j = 0; j < 8; j++) begin
      t = $urandom_range(0, 63);
      s = $urandom_range(0, 7);
      run_job(t, s, 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3), "rand");
    end
    idle_cycles(1, "rand");

    // Reset in the middle of HOLD: 10 -> 30 by 7 advances 17,24,30.
    run_job(10, 7, 1'b0, "t6 pre");
    idle_cycles(1, "t6 pre");
    start  = 1'b1;
    target = 6'd30;
    step   = 3'd7;
    @(negedge slow);
    start = 1'b0;
    repeat (8) @(negedge slow);
    check("t6 in hold busy", 32'(busy), 1);
    check("t6 in hold hart", 32'(hart), 30);
    #2 reset = 1'b0;
    #1;
    check("t6 async hart", 32'(hart), 63);
    check("t6 async busy", 32'(busy), 0);
    check("t6 async settled", 32'(settled), 0);
    @(negedge slow);
    reset = 1'b1;
    model_hart = 63;
    idle_cycles(8, "t6 post");
`else
    begin
      int prev, dlt;
      bit done;
      prev = 63;
      done = 1'b0;
      start  = 1'b1;
      target = '0;
      step   = 3'd4;
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge slow);
        start = 1'b0;
        if (32'(hart) != 32'(prev)) begin
          dlt = prev - int'(hart);
          check("noise delta ok", ((dlt == 3 || dlt == 4) || (hart == 0 && dlt > 0 && dlt <= 4)) ? 1 : 0, 1);
          prev = int'(hart);
        end
        if (settled === 1'b1) done = 1'b1;
      end
      check("noise settled seen", 32'(done), 1);
      check("noise final hart", 32'(hart), 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
